// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Push-button synchroniser, tick-sampled debouncer and
//                press/release/auto-repeat event generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int                N_KEYS       = 4,
    parameter int                ACTIVE_LOW   = 1,
    parameter int                STABLE_TICKS = 3,
    parameter int                REPEAT_DELAY = 20,
    parameter int                REPEAT_RATE  = 5,
    parameter logic [N_KEYS-1:0] REPEAT_MASK  = 4'b0111
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              tick_input,
    input  logic [N_KEYS-1:0] raw_keys,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_fire
);

    localparam int                 c_deb_w      = $clog2(STABLE_TICKS + 1);
    localparam int                 c_rep_w      = $clog2(REPEAT_DELAY + 1);
    localparam logic [c_deb_w-1:0] c_deb_last   = c_deb_w'(STABLE_TICKS - 1);
    localparam logic [c_rep_w-1:0] c_rep_delay  = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_rep_w-1:0] c_rep_reload = c_rep_w'(REPEAT_DELAY - REPEAT_RATE);
    // Idle (released) pin level, so the synchroniser wakes up without a press.
    localparam logic               c_released   = (ACTIVE_LOW != 0);

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        logic               r_sync1_q, w_sync1_d;
        logic               r_sync2_q, w_sync2_d;
        logic               r_level_q, w_level_d;
        logic [c_deb_w-1:0] r_deb_cnt_q, w_deb_cnt_d;
        logic               r_press_q, w_press_d;
        logic               r_release_q, w_release_d;
        logic               r_fire_q, w_fire_d;
        logic               w_pressed;
        logic               w_rep_pulse;

        always_comb begin
            w_sync1_d   = raw_keys[gi];
            w_sync2_d   = r_sync1_q;
            w_pressed   = (ACTIVE_LOW != 0) ? ~r_sync2_q : r_sync2_q;
            w_level_d   = r_level_q;
            w_deb_cnt_d = r_deb_cnt_q;
            w_press_d   = 1'b0;
            w_release_d = 1'b0;
            if (tick_input) begin
                if (w_pressed == r_level_q) begin
                    w_deb_cnt_d = '0;
                end else if (r_deb_cnt_q == c_deb_last) begin
                    w_level_d   = ~r_level_q;
                    w_deb_cnt_d = '0;
                    w_press_d   = ~r_level_q;
                    w_release_d = r_level_q;
                end else begin
                    w_deb_cnt_d = r_deb_cnt_q + c_deb_w'(1);
                end
            end
            w_fire_d = w_press_d | w_rep_pulse;
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_sync1_q   <= c_released;
                r_sync2_q   <= c_released;
                r_level_q   <= 1'b0;
                r_deb_cnt_q <= '0;
                r_press_q   <= 1'b0;
                r_release_q <= 1'b0;
                r_fire_q    <= 1'b0;
            end else begin
                r_sync1_q   <= w_sync1_d;
                r_sync2_q   <= w_sync2_d;
                r_level_q   <= w_level_d;
                r_deb_cnt_q <= w_deb_cnt_d;
                r_press_q   <= w_press_d;
                r_release_q <= w_release_d;
                r_fire_q    <= w_fire_d;
            end
        end

        if (REPEAT_MASK[gi]) begin : g_rep
            logic [c_rep_w-1:0] r_rep_cnt_q, w_rep_cnt_d;
            logic [c_rep_w-1:0] w_rep_inc;

            // The reload value is below the delay, so the count never wraps.
            always_comb begin
                w_rep_cnt_d = r_rep_cnt_q;
                w_rep_inc   = r_rep_cnt_q + c_rep_w'(1);
                w_rep_pulse = 1'b0;
                if (!r_level_q) begin
                    w_rep_cnt_d = '0;
                end else if (tick_input) begin
                    if (w_press_d | w_release_d) begin
                        w_rep_cnt_d = '0;
                    end else if (w_rep_inc == c_rep_delay) begin
                        w_rep_pulse = 1'b1;
                        w_rep_cnt_d = c_rep_reload;
                    end else begin
                        w_rep_cnt_d = w_rep_inc;
                    end
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    r_rep_cnt_q <= '0;
                end else begin
                    r_rep_cnt_q <= w_rep_cnt_d;
                end
            end
        end else begin : g_no_rep
            assign w_rep_pulse = 1'b0;
        end

        assign key_level[gi]   = r_level_q;
        assign key_press[gi]   = r_press_q;
        assign key_release[gi] = r_release_q;
        assign key_fire[gi]    = r_fire_q;
    end

endmodule
`default_nettype wire
